keypad_color_bank: RTL and testbench

- Writer side of the 16-cell colour register bank that the VGA tile renderer reads.
- Scans a 4x4 active-low matrix keypad and debounces every key.
- Each new key press advances that tile's 3-bit colour index by one, wrapping 7->0.
- Serves the renderer's combinational read port: `posicion` in, `dirColor` out.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_color_bank_if.sv | 27 ++
 rtl/keypad_scanner.sv | 116 +++++++++++
 rtl/keypad_color_bank.sv | 85 ++++++++
 tb/tb_keypad_color_bank.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and key-to-tile mapping for the keypad colour bank.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package keypad_pkg;

   localparam int NTILE = 16;

   localparam logic [2:0] COLOR_WHITE = 3'd0;

   // Top-level sequencing states, kept as plain constants for older tools.
   typedef logic [0:0] state_t;
   localparam state_t SCAN  = 1'b0;
   localparam state_t CLEAR = 1'b1;

   // Row r / column c of the keypad lands on screen tile {3-c, 3-r}, so the
   // top-left key paints the last tile and the bottom-right key tile 0.
   function automatic logic [3:0] tile_of(input logic [1:0] row, input logic [1:0] col);
      return {2'd3 - col, 2'd3 - row};
   endfunction

endpackage

// File: rtl/keypad_color_bank_if.sv
// Pin bundle between the colour bank and its keypad / renderer / control side.
// Latency: none (wires only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
interface keypad_color_bank_if;

   logic [3:0] col_n;
   logic [3:0] row_n;
   logic       clear;
   logic [3:0] posicion;
   logic [2:0] dirColor;
   logic       key_valid;
   logic [3:0] key_code;
   logic       busy;

   // The colour bank itself.
   modport slave (
      input  row_n, clear, posicion,
      output col_n, dirColor, key_valid, key_code, busy
   );

   // Whatever surrounds it: keypad matrix, renderer and control logic.
   modport master (
      output row_n, clear, posicion,
      input  col_n, dirColor, key_valid, key_code, busy
   );

endinterface

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces every key and arbitrates one edge per frame.
// Latency: press strobe one cycle after the frame end in which the key became stable.
// Backpressure: freeze stalls the scan and holds an unconsumed press strobe until released.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_COUNT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       freeze,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       press_vld,
   output logic [3:0] press_code
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEB_COUNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_COUNT);

   logic [DW-1:0]    div;
   logic [1:0]       col;
   logic [NTILE-1:0] snap;
   logic [NTILE-1:0] raw;
   logic [NTILE-1:0] stable;
   logic [NTILE-1:0] stable_nxt;
   logic [CW-1:0]    cnt     [NTILE];
   logic [CW-1:0]    cnt_nxt [NTILE];
   logic             tick;
   logic             frame_end;
   logic             hit;
   logic [3:0]       hit_idx;

   // Last cycle of a column period, and the one that closes the frame.
   always_comb begin
      tick      = !freeze && (div == DIV_LAST);
      frame_end = tick && (col == 2'd3);
   end

   // Active column is driven low; it follows the scan counter directly.
   always_comb begin
      col_n = ~(4'b0001 << col);
   end

   // Frame image: earlier columns from the snapshot, current column live.
   always_comb begin
      raw = snap;
      raw[4*col +: 4] = ~row_n;
   end

   // Per-key debounce and lowest-tile-first arbitration of pending edges.
   // Snapshot index k = col*4+row maps to tile 15-k, so the highest pending
   // index is the lowest tile code and wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 4'd0;
      for (int k = 0; k < NTILE; k++) begin
         if (raw[k] != stable[k]) begin
            cnt_nxt[k] = (cnt[k] == DEB_MAX) ? DEB_MAX : cnt[k] + 1'b1;
         end else begin
            cnt_nxt[k] = '0;
         end
         if (cnt_nxt[k] == DEB_MAX) begin
            hit     = 1'b1;
            hit_idx = 4'(k);
         end
      end
      stable_nxt = stable;
      if (hit) begin
         stable_nxt[hit_idx] = ~stable[hit_idx];
         cnt_nxt[hit_idx]    = '0;
      end
   end

   // Column divider, snapshot capture, debounce state and press strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= '0;
         col        <= 2'd0;
         snap       <= '0;
         stable     <= '0;
         press_vld  <= 1'b0;
         press_code <= 4'd0;
         for (int k = 0; k < NTILE; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         if (!freeze) begin
            if (tick) begin
               div             <= '0;
               col             <= col + 2'd1;
               snap[4*col +: 4] <= ~row_n;
            end else begin
               div <= div + 1'b1;
            end
         end
         if (frame_end) begin
            stable <= stable_nxt;
            for (int k = 0; k < NTILE; k++) begin
               cnt[k] <= cnt_nxt[k];
            end
            // Only a release-to-press transition produces a strobe.
            press_vld <= hit && raw[hit_idx];
            if (hit && raw[hit_idx]) begin
               press_code <= tile_of(hit_idx[1:0], hit_idx[3:2]);
            end
         end else if (!freeze) begin
            press_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/keypad_color_bank.sv
// 16-tile colour bank: keypad presses bump a tile's colour, clear sweeps all tiles to white.
// Latency: increment and key_valid one cycle after the press strobe; read port combinational.
// Backpressure: presses arriving during a clear sweep are held and applied when it ends.
module keypad_color_bank
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_COUNT = 10
) (
   input  logic                clk,
   input  logic                rst,
   keypad_color_bank_if.slave  bus
);

   state_t     state;
   logic [3:0] clr_idx;
   logic [2:0] bank [NTILE];
   logic       freeze;
   logic       press_vld;
   logic [3:0] press_code;
   logic       key_valid;
   logic [3:0] key_code;

   // The scan stops for the whole sweep so no frame can end unobserved.
   always_comb begin
      freeze = (state == CLEAR);
   end

   keypad_scanner #(
      .SCAN_DIV  (SCAN_DIV),
      .DEB_COUNT (DEB_COUNT)
   ) u_scanner (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .row_n      (bus.row_n),
      .col_n      (bus.col_n),
      .press_vld  (press_vld),
      .press_code (press_code)
   );

   // Bank writes, event reporting and the clear sweep sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         clr_idx   <= 4'd0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         for (int i = 0; i < NTILE; i++) begin
            bank[i] <= COLOR_WHITE;
         end
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               // A press landing with the clear request still completes first.
               if (press_vld) begin
                  bank[press_code] <= bank[press_code] + 3'd1;
                  key_valid        <= 1'b1;
                  key_code         <= press_code;
               end
               if (bus.clear) begin
                  state   <= CLEAR;
                  clr_idx <= 4'd0;
               end
            end
            default: begin
               bank[clr_idx] <= COLOR_WHITE;
               clr_idx       <= clr_idx + 4'd1;
               // clr_idx wraps to 0, so a still-high clear simply sweeps again.
               if (clr_idx == 4'(NTILE - 1) && !bus.clear) begin
                  state <= SCAN;
               end
            end
         endcase
      end
   end

   // Renderer read port: old data on a same-cycle write, new data after the edge.
   assign bus.dirColor  = bank[bus.posicion];
   assign bus.busy      = (state == CLEAR);
   assign bus.key_valid = key_valid;
   assign bus.key_code  = key_code;

endmodule

// File: tb/tb_keypad_color_bank.sv
// Directed bench for keypad_color_bank with a tile-colour model and per-cycle compare.
// Latency: n/a (simulation only).
// Backpressure: n/a.
module tb_keypad_color_bank;

   logic clk;
   logic rst;

   keypad_color_bank_if bus();

   keypad_color_bank #(
      .SCAN_DIV  (4),
      .DEB_COUNT (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Physical keypad: held[r][c] shorts row r to column c.
   logic [3:0] held [4];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         bus.row_n[r] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (!bus.col_n[c] && held[r][c]) bus.row_n[r] = 1'b0;
         end
      end
   end

   // Renderer address: walks all tiles, or is pinned for a literal read.
   logic       pin_en;
   logic [3:0] pin_pos;

   initial begin
      bus.posicion = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         bus.posicion = pin_en ? pin_pos : bus.posicion + 4'd1;
      end
   end

   // Model: expected press order, tile colours and clear sweep progress.
   int         exp_q [$];
   int         mb [16];
   int         mk;
   int         cmp_code;
   int         cmp_exp;

   initial begin
      mk = 0;
      for (int i = 0; i < 16; i++) mb[i] = 0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.key_valid) begin
            if (exp_q.size() == 0) begin
               chk("key_valid_unexpected", int'(bus.key_code) + 100, -1);
            end else begin
               cmp_code = exp_q.pop_front();
               chk("key_code", int'(bus.key_code), cmp_code);
               mb[cmp_code] = (mb[cmp_code] + 1) % 8;
            end
         end
         // During sweep cycle k, tiles 0..k-2 have already been whitened.
         if (mk != 0 && int'(bus.posicion) < mk - 1) cmp_exp = 0;
         else cmp_exp = mb[bus.posicion];
         chk("dirColor", int'(bus.dirColor), cmp_exp);
         chk("busy", int'(bus.busy), (mk != 0) ? 1 : 0);
      end
      // Advance the model across the coming edge using the inputs it will sample.
      if (rst) begin
         mk = 0;
         for (int i = 0; i < 16; i++) mb[i] = 0;
      end else if (mk == 0) begin
         if (bus.clear) mk = 1;
      end else if (mk == 16) begin
         for (int i = 0; i < 16; i++) mb[i] = 0;
         mk = bus.clear ? 1 : 0;
      end else begin
         mk++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic read_tile(input string name, input int t, input int req);
      pin_pos = 4'(t);
      pin_en  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(name, int'(bus.dirColor), req);
      @(posedge clk);
      #2;
      pin_en = 1'b0;
   endtask

   task automatic tap(input int r, input int c, input int code, input bit expect_evt);
      if (expect_evt) exp_q.push_back(code);
      held[r][c] = 1'b1;
      cycles(64);
      held[r][c] = 1'b0;
      cycles(64);
   endtask

   task automatic do_clear(input int ncyc, input int exp_busy);
      int cnt;
      cnt = 0;
      bus.clear = 1'b1;
      for (int i = 0; i < ncyc + exp_busy + 8; i++) begin
         @(negedge clk);
         if (bus.busy) cnt++;
         @(posedge clk);
         #2;
         if (i == ncyc - 1) bus.clear = 1'b0;
      end
      chk("busy_cycles", cnt, exp_busy);
   endtask

   initial begin
      rst       = 1'b1;
      bus.clear = 1'b0;
      pin_en    = 1'b0;
      pin_pos   = 4'd0;
      for (int r = 0; r < 4; r++) held[r] = 4'b0000;

      // Reset.
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_col_n", int'(bus.col_n), 4'b1110);
      chk("reset_key_valid", int'(bus.key_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_key_code", int'(bus.key_code), 0);
      @(posedge clk);
      #2;
      for (int t = 0; t < 16; t++) read_tile("reset_tile", t, 0);

      // Single press of row0/col0 -> tile 15.
      tap(0, 0, 15, 1'b1);
      chk("single_events_missing", exp_q.size(), 0);
      read_tile("single_tile15", 15, 1);
      read_tile("single_tile11", 11, 0);
      read_tile("single_tile0", 0, 0);

      // Wrap: row3/col3 -> tile 0, eight presses return it to 0, ninth gives 1.
      for (int n = 0; n < 8; n++) tap(3, 3, 0, 1'b1);
      chk("wrap_events_missing", exp_q.size(), 0);
      read_tile("wrap_tile0_after8", 0, 0);
      tap(3, 3, 0, 1'b1);
      read_tile("wrap_tile0_after9", 0, 1);

      // Bounce: row1/col2 -> tile 6 held for one frame only.
      held[1][2] = 1'b1;
      cycles(16);
      held[1][2] = 1'b0;
      cycles(64);
      read_tile("bounce_tile6", 6, 0);
      read_tile("bounce_tile5", 5, 0);

      // Simultaneous row0/col0 (tile 15) and row1/col0 (tile 14): 14 served first.
      exp_q.push_back(14);
      exp_q.push_back(15);
      held[0][0] = 1'b1;
      held[1][0] = 1'b1;
      cycles(64);
      held[0][0] = 1'b0;
      held[1][0] = 1'b0;
      cycles(64);
      chk("simul_events_missing", exp_q.size(), 0);
      read_tile("simul_tile14", 14, 1);
      read_tile("simul_tile15", 15, 2);

      // Clear while row0/col1 (tile 11) is held.
      exp_q.push_back(11);
      held[0][1] = 1'b1;
      cycles(64);
      read_tile("held_tile11", 11, 1);
      do_clear(1, 16);
      read_tile("clear_tile15", 15, 0);
      read_tile("clear_tile11", 11, 0);
      read_tile("clear_tile0", 0, 0);
      cycles(64);
      held[0][1] = 1'b0;
      cycles(64);
      chk("held_no_refire", exp_q.size(), 0);
      tap(0, 1, 11, 1'b1);
      chk("repress_events_missing", exp_q.size(), 0);
      read_tile("repress_tile11", 11, 1);

      // Level clear held past the first sweep runs a second one.
      do_clear(17, 32);
      read_tile("double_clear_tile11", 11, 0);
      cycles(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
